// File: rtl/sram_ctl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctl_pkg
// Shared definitions for the asynchronous SRAM controller: the controller
// state encoding and the default timing/width parameters.
// ---------------------------------------------------------------------------
package sram_ctl_pkg;

    // Default external word-address width.
    localparam int ADDR_W_DEF   = 18;
    // Default access-strobe length in cycles (legal 1..15).
    localparam int WAIT_CYC_DEF = 2;
    // Default idle cycles between a read and the next access (legal 0..3).
    localparam int TURN_CYC_DEF = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLD,
        ST_TURN
    } state_t;

endpackage

// File: rtl/sram_ctl.sv
// ---------------------------------------------------------------------------
// sram_ctl
// Single-port controller for an asynchronous 16-bit SRAM behind a 16-bit
// bidirectional pad bank.  The pad bank itself lives in the parent; this
// block only drives its D (data) and E (per-bit enable) inputs and reads
// its Y outputs.
//
// Access sequence: IDLE -> SETUP (1) -> ACCESS (WAIT_CYC) -> HOLD (1 or 2)
// -> [TURN (TURN_CYC), reads only] -> IDLE.  Every output is a flop, so
// the SRAM strobes and pad enables are glitch-free.
//
// Ports
//   CLK, RESET             clock (rising edge), async active-high reset
//   REQ, WE, ADDR, WDATA   request strobe (taken only while READY=1),
//                          direction (1=write), word address, write data
//   READY                  controller idle and able to take a request
//   RDATA, RVALID          read data, one-cycle valid pulse
//   SRAM_ADDR              SRAM address pins
//   SRAM_CE_N/OE_N/WE_N    SRAM strobes, active-low
//   IO_D, IO_E             pad bank drive data and per-bit output enables
//   IO_Y                   pad bank received data
//
// Configuration
//   SRAM_CTL_RDREG_EN      when defined, IO_Y passes through an input
//                          register before RDATA capture; HOLD grows to two
//                          cycles and read latency becomes WAIT_CYC+3.
// ---------------------------------------------------------------------------
module sram_ctl
    import sram_ctl_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int WAIT_CYC = WAIT_CYC_DEF,
    parameter int TURN_CYC = TURN_CYC_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [15:0]       WDATA,
    output logic              READY,
    output logic [15:0]       RDATA,
    output logic              RVALID,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic [15:0]       IO_D,
    output logic [15:0]       IO_E,
    input  logic [15:0]       IO_Y
);

    // Counter reload values: the counter runs down to zero, so each phase
    // loads its length minus one.
    localparam logic [3:0] ACC_LAST  = 4'(WAIT_CYC - 1);
    localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);
`ifdef SRAM_CTL_RDREG_EN
    localparam logic [3:0] HOLD_LAST = 4'd1;
`else
    localparam logic [3:0] HOLD_LAST = 4'd0;
`endif

    state_t     state;
    logic [3:0] cnt;
    logic       is_write;

`ifdef SRAM_CTL_RDREG_EN
    logic [15:0] io_y_q;

    // NOTE: pure data pipeline register, so it carries no reset; its content
    // is only consumed after a full ACCESS phase has refilled it.
    always_ff @(posedge CLK) begin
        io_y_q <= IO_Y;
    end
`endif

    // NOTE: all state and outputs use non-blocking assignments so every
    // register samples the values from before this edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            is_write  <= 1'b0;
            READY     <= 1'b0;
            RDATA     <= 16'h0000;
            RVALID    <= 1'b0;
            SRAM_ADDR <= '0;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            IO_D      <= 16'h0000;
            IO_E      <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (READY && REQ) begin
                        // Accept: latch the request and drive the SETUP
                        // values so they are visible during SETUP itself.
                        READY     <= 1'b0;
                        state     <= ST_SETUP;
                        is_write  <= WE;
                        SRAM_ADDR <= ADDR;
                        SRAM_CE_N <= 1'b0;
                        if (WE) begin
                            IO_D <= WDATA;
                            IO_E <= 16'hFFFF;
                        end else begin
                            SRAM_OE_N <= 1'b0;
                        end
                    end else begin
                        // Also covers the first cycle after reset release.
                        READY <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    state <= ST_ACCESS;
                    cnt   <= ACC_LAST;
                    if (is_write) begin
                        SRAM_WE_N <= 1'b0;
                    end
                end

                ST_ACCESS: begin
                    if (cnt == 4'd0) begin
                        state     <= ST_HOLD;
                        cnt       <= HOLD_LAST;
                        SRAM_WE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
`ifndef SRAM_CTL_RDREG_EN
                        // Capture straight from the pads on the last edge
                        // with OE_N still low.
                        if (!is_write) begin
                            RDATA  <= IO_Y;
                            RVALID <= 1'b1;
                        end
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                ST_HOLD: begin
                    if (cnt != 4'd0) begin
                        // First of two HOLD cycles: io_y_q still holds the
                        // sample taken on the last ACCESS edge.
                        cnt <= cnt - 4'd1;
`ifdef SRAM_CTL_RDREG_EN
                        if (!is_write) begin
                            RDATA  <= io_y_q;
                            RVALID <= 1'b1;
                        end
`endif
                    end else begin
                        RVALID    <= 1'b0;
                        SRAM_CE_N <= 1'b1;
                        IO_E      <= 16'h0000;
                        if (!is_write && (TURN_CYC != 0)) begin
                            state <= ST_TURN;
                            cnt   <= TURN_LAST;
                        end else begin
                            state <= ST_IDLE;
                            READY <= 1'b1;
                        end
                    end
                end

                ST_TURN: begin
                    // Bus left floating so the SRAM output driver can turn
                    // off before the pad bank may drive again.
                    if (cnt == 4'd0) begin
                        state <= ST_IDLE;
                        READY <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
